// File: rtl/mem_ctrl.sv
// Memory controller for the fetch and load/store stages.
// Turns instruction-fetch word reads and load/store accesses into one-byte
// transactions on a single-port RAM. Loads take priority over fetches, and
// each result is returned with a one-cycle enable pulse.
module mem_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              jump_or_not,
   input  logic              if_request,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_inst,
   output logic              if_enable,
   input  logic              mem_request,
   input  logic              mem_wr,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [1:0]        mem_len,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_enable,
   input  logic [7:0]        ram_din,
   output logic [7:0]        ram_dout,
   output logic [ADDR_W-1:0] ram_a,
   output logic              ram_wr
);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_IF_READ   = 2'd1;
   localparam logic [1:0] ST_MEM_READ  = 2'd2;
   localparam logic [1:0] ST_MEM_WRITE = 2'd3;

   // Number of bytes moved for a load/store of the given size code.
   function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
      logic [2:0] n;
      case (len)
         2'b00:   n = 3'd1;
         2'b01:   n = 3'd2;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

   logic [1:0]        state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;       // index of the next byte edge, 1..N
   logic [2:0]        n_q, n_d;           // total bytes in this access
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] result_q, result_d; // bytes gathered so far
   logic [DATA_W-1:0] if_inst_q, if_inst_d;
   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
   logic              if_en_q, if_en_d;
   logic              mem_en_q, mem_en_d;
   logic [ADDR_W-1:0] ram_a_q, ram_a_d;
   logic [7:0]        ram_dout_q, ram_dout_d;
   logic              ram_wr_q, ram_wr_d;

   logic [1:0]        byte_idx_s;  // result byte captured at this edge
   logic [ADDR_W-1:0] next_addr_s;
   logic [DATA_W-1:0] merged_s;
   logic              last_s;
   logic              busy_s;      // an enable is still visible to a requester

   assign byte_idx_s  = cnt_q[1:0] - 2'd1;
   assign next_addr_s = addr_q + ADDR_W'(cnt_q);
   assign last_s      = (cnt_q == n_q);
   assign busy_s      = if_en_q | mem_en_q;

   // Next-state logic: arbitration, byte sequencing and result assembly.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      n_d         = n_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      result_d    = result_q;
      if_inst_d   = if_inst_q;
      mem_rdata_d = mem_rdata_q;
      if_en_d     = 1'b0;
      mem_en_d    = 1'b0;
      ram_a_d     = ram_a_q;
      ram_dout_d  = ram_dout_q;
      ram_wr_d    = 1'b0;

      merged_s = result_q;
      merged_s[{byte_idx_s, 3'b000} +: 8] = ram_din;

      case (state_q)
         ST_IDLE: begin
            if (busy_s) begin
               state_d = ST_IDLE;
            end else if (mem_request) begin
               addr_d   = mem_addr;
               n_d      = len_to_bytes(mem_len);
               wdata_d  = mem_wdata;
               result_d = '0;
               cnt_d    = 3'd1;
               ram_a_d  = mem_addr;
               if (mem_wr) begin
                  ram_dout_d = mem_wdata[7:0];
                  ram_wr_d   = 1'b1;
                  state_d    = ST_MEM_WRITE;
               end else begin
                  state_d    = ST_MEM_READ;
               end
            end else if (if_request && !jump_or_not) begin
               addr_d   = if_addr;
               n_d      = 3'd4;
               result_d = '0;
               cnt_d    = 3'd1;
               ram_a_d  = if_addr;
               state_d  = ST_IF_READ;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_IF_READ: begin
            if (jump_or_not) begin
               // Flushed fetch: drop it silently, no enable.
               state_d = ST_IDLE;
            end else if (last_s) begin
               result_d  = merged_s;
               if_inst_d = merged_s;
               if_en_d   = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               result_d = merged_s;
               ram_a_d  = next_addr_s;
               cnt_d    = cnt_q + 3'd1;
            end
         end

         ST_MEM_READ: begin
            result_d = merged_s;
            if (last_s) begin
               mem_rdata_d = merged_s;
               mem_en_d    = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               ram_a_d = next_addr_s;
               cnt_d   = cnt_q + 3'd1;
            end
         end

         ST_MEM_WRITE: begin
            if (last_s) begin
               mem_en_d = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               ram_a_d    = next_addr_s;
               ram_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
               ram_wr_d   = 1'b1;
               cnt_d      = cnt_q + 3'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; everything freezes while rdy is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 3'd0;
         n_q         <= 3'd0;
         addr_q      <= '0;
         wdata_q     <= '0;
         result_q    <= '0;
         if_inst_q   <= '0;
         mem_rdata_q <= '0;
         if_en_q     <= 1'b0;
         mem_en_q    <= 1'b0;
         ram_a_q     <= '0;
         ram_dout_q  <= 8'h00;
         ram_wr_q    <= 1'b0;
      end else if (rdy) begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         n_q         <= n_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         result_q    <= result_d;
         if_inst_q   <= if_inst_d;
         mem_rdata_q <= mem_rdata_d;
         if_en_q     <= if_en_d;
         mem_en_q    <= mem_en_d;
         ram_a_q     <= ram_a_d;
         ram_dout_q  <= ram_dout_d;
         ram_wr_q    <= ram_wr_d;
      end
   end

   assign if_inst    = if_inst_q;
   assign if_enable  = if_en_q;
   assign mem_rdata  = mem_rdata_q;
   assign mem_enable = mem_en_q;
   assign ram_a      = ram_a_q;
   assign ram_dout   = ram_dout_q;
   // A held write strobe must not reach the RAM while the system is stalled.
   assign ram_wr     = ram_wr_q & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: table of directed transactions, hand-written
// multi-cycle sequences (arbitration, flush, stall, reset) and randomized
// traffic checked against a byte-array model of the RAM.
module tb_mem_ctrl;

   localparam int OP_IF = 0;
   localparam int OP_LD = 1;
   localparam int OP_ST = 2;

   logic        clk = 1'b0;
   logic        rst, rdy, jump_or_not;
   logic        if_request, if_enable;
   logic [31:0] if_addr, if_inst;
   logic        mem_request, mem_wr, mem_enable;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  mem_len;
   logic [7:0]  ram_din, ram_dout;
   logic [31:0] ram_a;
   logic        ram_wr;

   int n_checks = 0;
   int n_fail   = 0;

   // Clock generation.
   always #5 clk = ~clk;

   mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .jump_or_not(jump_or_not),
      .if_request(if_request), .if_addr(if_addr), .if_inst(if_inst), .if_enable(if_enable),
      .mem_request(mem_request), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_len(mem_len),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_enable(mem_enable),
      .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
   );

   // Bench RAM (64 KiB, low address bits), its back-door poke port, and the model copy.
   logic [7:0]  ram [0:65535];
   logic [7:0]  model_mem [0:65535];
   logic        poke_en = 1'b0;
   logic [15:0] poke_a = 16'h0000;
   logic [7:0]  poke_d = 8'h00;
   int          wr_count = 0;

   // RAM output follows the registered address presented by the controller.
   assign ram_din = ram[ram_a[15:0]];

   // RAM write port: controller writes, otherwise back-door pokes; counts write strobes.
   always @(posedge clk) begin
      if (ram_wr) begin
         ram[ram_a[15:0]] <= ram_dout;
         wr_count <= wr_count + 1;
      end else if (poke_en) begin
         ram[poke_a] <= poke_d;
      end
   end

   typedef struct {
      int          op;
      logic [31:0] addr;
      logic [1:0]  len;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      int          exp_edges;
      int          exp_wr;
   } vec_t;

   vec_t vec [12];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   function automatic int len_bytes(input logic [1:0] len);
      return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a, input int nb);
      logic [31:0] r, ai;
      r = 32'h0;
      for (int i = 0; i < 4; i++) begin
         if (i < nb) begin
            ai = a + 32'(i);
            r = r | (32'(model_mem[ai[15:0]]) << (8 * i));
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] ram_read(input logic [31:0] a, input int nb);
      logic [31:0] r, ai;
      r = 32'h0;
      for (int i = 0; i < 4; i++) begin
         if (i < nb) begin
            ai = a + 32'(i);
            r = r | (32'(ram[ai[15:0]]) << (8 * i));
         end
      end
      return r;
   endfunction

   task automatic model_store(input logic [31:0] a, input int nb, input logic [31:0] wd);
      logic [31:0] ai;
      for (int i = 0; i < nb; i++) begin
         ai = a + 32'(i);
         model_mem[ai[15:0]] = wd[8 * i +: 8];
      end
   endtask

   task automatic poke(input logic [31:0] a, input logic [7:0] d);
      poke_en = 1'b1;
      poke_a  = a[15:0];
      poke_d  = d;
      model_mem[a[15:0]] = d;
      tick();
      poke_en = 1'b0;
   endtask

   // One complete request/enable handshake; edges counts rdy-high clock edges
   // from raising the request up to and including the one that shows the enable.
   task automatic run_txn(input int op, input logic [31:0] addr, input logic [1:0] len,
                          input logic [31:0] wd, input bit rnd_rdy,
                          output logic [31:0] rd, output int edges, output int wrs,
                          output bit wrong_en, output bit timed_out);
      int wr0;
      wr0 = wr_count;
      edges = 0;
      wrong_en = 1'b0;
      timed_out = 1'b1;
      rd = 32'h0;
      if (op == OP_IF) begin
         if_request = 1'b1;
         if_addr    = addr;
      end else begin
         mem_request = 1'b1;
         mem_wr      = (op == OP_ST);
         mem_addr    = addr;
         mem_len     = len;
         mem_wdata   = wd;
      end
      for (int c = 0; c < 60; c++) begin
         if (rnd_rdy) rdy = ($urandom_range(0, 3) != 0);
         tick();
         if (rdy) edges++;
         if ((op == OP_IF) ? mem_enable : if_enable) wrong_en = 1'b1;
         if ((op == OP_IF) ? if_enable : mem_enable) begin
            rd = (op == OP_IF) ? if_inst : mem_rdata;
            timed_out = 1'b0;
            break;
         end
      end
      rdy = 1'b1;
      if_request = 1'b0;
      mem_request = 1'b0;
      mem_wr = 1'b0;
      tick();
      wrs = wr_count - wr0;
   endtask

   logic [31:0] got, exp, a, wd;
   logic [1:0]  ln;
   int          e, w, nb, op, w0;
   bit          we, to;

   // Main test sequence.
   initial begin
      rst = 1'b0; rdy = 1'b1; jump_or_not = 1'b0;
      if_request = 1'b0; if_addr = 32'h0;
      mem_request = 1'b0; mem_wr = 1'b0; mem_addr = 32'h0; mem_len = 2'b00; mem_wdata = 32'h0;
      tick();
      tick();
      check("reset_ram_a", ram_a, 32'h0);
      check("reset_ram_wr_dout", {23'h0, ram_wr, ram_dout}, 32'h0);
      check("reset_enables", {30'h0, if_enable, mem_enable}, 32'h0);
      check("reset_if_inst", if_inst, 32'h0);
      check("reset_mem_rdata", mem_rdata, 32'h0);
      rst = 1'b1;
      tick();

      // Preload RAM contents used by the directed transactions.
      poke(32'h1004, 8'h13); poke(32'h1005, 8'h05); poke(32'h1006, 8'h00); poke(32'h1007, 8'h00);
      poke(32'h2000, 8'hEF); poke(32'h2001, 8'hBE); poke(32'h2002, 8'hAD); poke(32'h2003, 8'hDE);
      poke(32'h3001, 8'hAA);
      poke(32'hFFFE, 8'h11); poke(32'hFFFF, 8'h22); poke(32'h0000, 8'h33);
      poke(32'h0001, 8'h44); poke(32'h0002, 8'h55);

      vec[0]  = '{OP_IF, 32'h0000_1004, 2'b00, 32'h0,         32'h0000_0513, 5, 0};
      vec[1]  = '{OP_LD, 32'h0000_2000, 2'b10, 32'h0,         32'hDEAD_BEEF, 5, 0};
      vec[2]  = '{OP_ST, 32'h0000_3000, 2'b00, 32'h1234_5678, 32'h0,         2, 1};
      vec[3]  = '{OP_ST, 32'h0000_3002, 2'b01, 32'h1234_5678, 32'h0,         3, 2};
      vec[4]  = '{OP_LD, 32'h0000_3000, 2'b00, 32'h0,         32'h0000_0078, 2, 0};
      vec[5]  = '{OP_LD, 32'h0000_3002, 2'b01, 32'h0,         32'h0000_5678, 3, 0};
      vec[6]  = '{OP_LD, 32'h0000_3000, 2'b11, 32'h0,         32'h5678_AA78, 5, 0};
      vec[7]  = '{OP_LD, 32'h0000_2001, 2'b01, 32'h0,         32'h0000_ADBE, 3, 0};
      vec[8]  = '{OP_LD, 32'hFFFF_FFFE, 2'b10, 32'h0,         32'h4433_2211, 5, 0};
      vec[9]  = '{OP_IF, 32'hFFFF_FFFF, 2'b00, 32'h0,         32'h5544_3322, 5, 0};
      vec[10] = '{OP_ST, 32'h0000_3004, 2'b10, 32'hA1B2_C3D4, 32'h0,         5, 4};
      vec[11] = '{OP_LD, 32'h0000_3004, 2'b10, 32'h0,         32'hA1B2_C3D4, 5, 0};

      for (int i = 0; i < 12; i++) begin
         run_txn(vec[i].op, vec[i].addr, vec[i].len, vec[i].wdata, 1'b0, got, e, w, we, to);
         check($sformatf("vec%0d_timeout", i), {31'h0, to}, 32'h0);
         check($sformatf("vec%0d_latency", i), e, vec[i].exp_edges);
         check($sformatf("vec%0d_writes", i), w, vec[i].exp_wr);
         check($sformatf("vec%0d_other_enable", i), {31'h0, we}, 32'h0);
         check($sformatf("vec%0d_pulse_width", i), {30'h0, if_enable, mem_enable}, 32'h0);
         if (vec[i].op == OP_ST) model_store(vec[i].addr, len_bytes(vec[i].len), vec[i].wdata);
         else check($sformatf("vec%0d_data", i), got, vec[i].exp_data);
      end

      // Fetch: address steps one byte per cycle, enable four edges after accept.
      if_request = 1'b1; if_addr = 32'h1004;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("if_seq_ram_a%0d", k), ram_a, 32'h1004 + 32'(k));
         check($sformatf("if_seq_no_en%0d", k), {31'h0, if_enable}, 32'h0);
      end
      tick();
      check("if_seq_enable", {31'h0, if_enable}, 32'h1);
      check("if_seq_inst", if_inst, 32'h0000_0513);
      if_request = 1'b0;
      tick();

      // Simultaneous requests: load wins, fetch waits for mem_enable to drop.
      if_request = 1'b1; if_addr = 32'h1004;
      mem_request = 1'b1; mem_wr = 1'b0; mem_addr = 32'h2000; mem_len = 2'b10;
      tick();
      check("arb_mem_first", ram_a, 32'h2000);
      tick(); tick(); tick(); tick();
      check("arb_mem_enable", {30'h0, if_enable, mem_enable}, 32'h1);
      check("arb_mem_data", mem_rdata, 32'hDEAD_BEEF);
      mem_request = 1'b0;
      tick();
      check("arb_blocked_ram_a", ram_a, 32'h2003);
      check("arb_enable_dropped", {30'h0, if_enable, mem_enable}, 32'h0);
      tick();
      check("arb_if_accept", ram_a, 32'h1004);
      tick(); tick(); tick(); tick();
      check("arb_if_enable", {30'h0, if_enable, mem_enable}, 32'h2);
      check("arb_if_inst", if_inst, 32'h0000_0513);
      if_request = 1'b0;
      tick();

      // Flush two cycles after a fetch accept, then a fresh fetch to 0x0.
      poke(32'h0, 8'h93); poke(32'h1, 8'h00); poke(32'h2, 8'h10); poke(32'h3, 8'h00);
      w0 = wr_count;
      if_request = 1'b1; if_addr = 32'h1004;
      tick();
      tick();
      jump_or_not = 1'b1; if_request = 1'b0;
      tick();
      jump_or_not = 1'b0; if_request = 1'b1; if_addr = 32'h0;
      check("flush_no_enable", {31'h0, if_enable}, 32'h0);
      tick();
      check("flush_new_accept", ram_a, 32'h0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("flush_no_enable%0d", k), {31'h0, if_enable}, 32'h0);
      end
      tick();
      check("flush_refetch_enable", {31'h0, if_enable}, 32'h1);
      check("flush_refetch_inst", if_inst, 32'h0010_0093);
      check("flush_no_writes", wr_count - w0, 32'h0);
      if_request = 1'b0;
      tick();

      // Stall for three cycles in the middle of a word load.
      mem_request = 1'b1; mem_wr = 1'b0; mem_addr = 32'h2000; mem_len = 2'b10;
      tick();
      tick();
      check("stall_ld_ram_a", ram_a, 32'h2001);
      rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("stall_ld_hold%0d", k), {ram_wr, mem_enable, ram_a[29:0]}, 32'h2001);
      end
      rdy = 1'b1;
      tick();
      check("stall_ld_resume", ram_a, 32'h2002);
      tick();
      check("stall_ld_not_early", {31'h0, mem_enable}, 32'h0);
      tick();
      check("stall_ld_enable", {31'h0, mem_enable}, 32'h1);
      check("stall_ld_data", mem_rdata, 32'hDEAD_BEEF);
      mem_request = 1'b0;
      tick();

      // Stall during a store: the held write strobe is masked.
      w0 = wr_count;
      mem_request = 1'b1; mem_wr = 1'b1; mem_addr = 32'h5000; mem_len = 2'b10; mem_wdata = 32'h0BAD_F00D;
      tick();
      rdy = 1'b0;
      #1;
      check("stall_st_wr_masked", {31'h0, ram_wr}, 32'h0);
      tick();
      check("stall_st_ram_a", ram_a, 32'h5000);
      rdy = 1'b1;
      #1;
      check("stall_st_wr_back", {31'h0, ram_wr}, 32'h1);
      to = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (mem_enable) begin
            to = 1'b0;
            break;
         end
      end
      check("stall_st_timeout", {31'h0, to}, 32'h0);
      mem_request = 1'b0; mem_wr = 1'b0;
      tick();
      model_store(32'h5000, 4, 32'h0BAD_F00D);
      check("stall_st_writes", wr_count - w0, 32'd4);
      check("stall_st_ram", ram_read(32'h5000, 4), model_read(32'h5000, 4));

      // Reset in the middle of a word store after two bytes were written.
      poke(32'h6000, 8'h00); poke(32'h6001, 8'h00); poke(32'h6002, 8'h55); poke(32'h6003, 8'h66);
      mem_request = 1'b1; mem_wr = 1'b1; mem_addr = 32'h6000; mem_len = 2'b10; mem_wdata = 32'hCAFE_F00D;
      tick(); tick(); tick();
      rst = 1'b0;
      #1;
      check("rst_mid_ram_a", ram_a, 32'h0);
      check("rst_mid_ram_wr_dout", {23'h0, ram_wr, ram_dout}, 32'h0);
      check("rst_mid_enables", {30'h0, if_enable, mem_enable}, 32'h0);
      check("rst_mid_rdata", mem_rdata, 32'h0);
      check("rst_mid_inst", if_inst, 32'h0);
      mem_request = 1'b0; mem_wr = 1'b0;
      tick();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("rst_no_enable%0d", k), {30'h0, if_enable, mem_enable}, 32'h0);
      end
      model_store(32'h6000, 2, 32'hCAFE_F00D);
      run_txn(OP_LD, 32'h6000, 2'b10, 32'h0, 1'b0, got, e, w, we, to);
      check("rst_after_latency", e, 32'd5);
      check("rst_after_data", got, 32'h6655_F00D);

      // Randomized traffic with random stalls against the byte-array model.
      for (int i = 0; i < 256; i++) poke(32'h4000 + 32'(i), 8'($urandom));
      for (int i = 0; i < 8; i++) poke(32'hFFF8 + 32'(i), 8'($urandom));
      for (int i = 0; i < 8; i++) poke(32'(i), 8'($urandom));
      for (int t = 0; t < 80; t++) begin
         op = $urandom_range(0, 2);
         ln = 2'($urandom_range(0, 3));
         nb = (op == OP_IF) ? 4 : len_bytes(ln);
         if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
         else a = 32'h4000 + 32'($urandom_range(0, 252));
         wd = $urandom;
         exp = model_read(a, nb);
         run_txn(op, a, ln, wd, 1'b1, got, e, w, we, to);
         check($sformatf("rand%0d_timeout", t), {31'h0, to}, 32'h0);
         check($sformatf("rand%0d_latency", t), e, 32'(1 + nb));
         check($sformatf("rand%0d_other_enable", t), {31'h0, we}, 32'h0);
         if (op == OP_ST) begin
            model_store(a, nb, wd);
            check($sformatf("rand%0d_writes", t), w, 32'(nb));
            check($sformatf("rand%0d_ram", t), ram_read(a, 4), model_read(a, 4));
         end else begin
            check($sformatf("rand%0d_writes", t), w, 32'h0);
            check($sformatf("rand%0d_data", t), got, exp);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller between the instruction-fetch / memory-access stages and the single-port, byte-wide unified RAM.
- Serves instruction-fetch word reads and load/store accesses by serialising them into one-byte RAM transactions.
- Arbitrates between the two requesters and returns each result with a one-cycle completion pulse.
- Sits directly upstream of ifetch: it consumes `if_addr`/`if_request` and produces `if_inst_i`/`if_enable`.

Parameters:
- ADDR_W, 32: address width of requester and RAM ports.
- DATA_W, 32: width of instruction and data words.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset.
- rdy  input  1  global ready; when low the block freezes.
- jump_or_not  input  1  pipeline flush; aborts an in-flight instruction fetch.
- if_request  input  1  fetch request (level, held until if_enable).
- if_addr  input  ADDR_W  fetch byte address.
- if_inst  output  DATA_W  fetched instruction word, little-endian.
- if_enable  output  1  one-cycle pulse; if_inst is valid.
- mem_request  input  1  load/store request (level, held until mem_enable).
- mem_wr  input  1  1 = store, 0 = load.
- mem_addr  input  ADDR_W  load/store byte address.
- mem_len  input  2  access size: 00 = 1 byte, 01 = 2 bytes, 10/11 = 4 bytes.
- mem_wdata  input  DATA_W  store data; low bytes are used.
- mem_rdata  output  DATA_W  load data, zero-extended.
- mem_enable  output  1  one-cycle pulse; load data valid or store complete.
- ram_din  input  8  RAM read byte; valid one cycle after its address.
- ram_dout  output  8  RAM write byte.
- ram_a  output  ADDR_W  RAM byte address.
- ram_wr  output  1  RAM write strobe.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, counter 0.
  - All outputs 0: if_inst, if_enable, mem_rdata, mem_enable, ram_a, ram_dout, ram_wr.
  - Reset mid-operation drops the access; no enable pulse is issued.
- States: IDLE, IF_READ, MEM_READ, MEM_WRITE.
- Byte count N: 4 for IF; 1, 2 or 4 for MEM per mem_len.
- All data and address outputs are registered. if_enable and mem_enable are 1 only in the cycle after completion, 0 otherwise.
- IDLE acceptance at edge E0:
  - mem_request has priority over if_request.
  - Requests are ignored in any cycle where if_enable or mem_enable is 1; this prevents re-accepting a request whose enable is in flight.
  - if_request is ignored in a cycle where jump_or_not is 1.
  - On accept: latch address, N and write data; set counter to 1.
  - Drive ram_a = addr.
  - Store only: drive ram_dout = byte 0 and ram_wr = 1.
- Read (IF_READ / MEM_READ), at edge Ek for k = 1..N:
  - Capture ram_din into result byte k-1 (byte 0 at bits 7:0).
  - If k < N: drive ram_a = addr + k.
  - At EN: return to IDLE and pulse the enable. Data is visible on if_inst / mem_rdata in the same cycle as the enable and is held afterwards.
  - Accept-to-enable latency is N edges: fetch = 4, LW = 4, LH = 2, LB = 1.
- Write (MEM_WRITE), at edge Ek:
  - If k < N: drive ram_a = addr + k, ram_dout = byte k, ram_wr = 1.
  - At EN: ram_wr = 0, pulse mem_enable, return to IDLE.
- Address increment wraps modulo 2^ADDR_W.
- Unused upper bytes of mem_rdata are 0; sign extension is the consumer's job.
- Flush: jump_or_not = 1 during IF_READ aborts at the next edge.
  - State goes to IDLE; if_enable is not pulsed; ram_wr stays 0.
  - MEM_READ and MEM_WRITE are never aborted by flush.
- Stall: when rdy = 0 at an edge, no register changes. While rdy = 0 the ram_wr output is forced to 0 combinationally (ram_wr = wr_reg & rdy).
- Requesters must hold request, address, len and data stable from request until their enable is observed.

Test Plan:
- IF fetch of if_addr = 0x00001004, RAM[0x1004..0x1007] = 13 05 00 00 -> ram_a steps 0x1004..0x1007 on consecutive cycles; if_enable pulses exactly 4 edges after accept with if_inst = 0x00000513.
- if_request and mem_request (LW, addr 0x2000, RAM bytes EF BE AD DE) raised in the same cycle -> LW served first with mem_rdata = 0xDEADBEEF; the fetch is then accepted only after mem_enable has dropped.
- SB then SH: mem_wdata = 0x12345678 to 0x3000 with len 00, then to 0x3002 with len 01.
  - SB -> exactly one ram_wr cycle writing 0x78 @0x3000.
  - SH -> two ram_wr cycles writing 0x78 @0x3002 and 0x56 @0x3003; mem_enable one cycle each.
  - LB of 0x3000 afterwards -> mem_rdata = 0x00000078.
- jump_or_not pulsed two cycles after an IF accept -> no if_enable; state IDLE; a new fetch to 0x0 raised the following cycle completes normally.
- rdy held low for 3 cycles mid-LW -> ram_wr stays 0, ram_a unchanged; completion delayed by exactly 3 cycles with correct data.
- rst asserted mid-SW (after 2 bytes written) -> all outputs 0 immediately; no mem_enable; after release, state IDLE and accepts a new request.
